mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: RAM_ADDRESS_BITS, default 32, word address width; DATA_BITS, default 32, word width; BLOCK_BITS, default 2, log2 of words per cache block (BLOCK_WORDS = 2**BLOCK_BITS).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cN_address  input  RAM_ADDRESS_BITS  requester N (N = 0, 1) word address.
REQ-005 cN_read_en  input  1  requester N block-fill request, held high until cN_mem_valid seen.
REQ-006 cN_write_en  input  1  requester N single-word write request, held high until cN_mem_valid seen.
REQ-007 cN_write_data  input  DATA_BITS  requester N write word.
REQ-008 cN_mem_valid  output  1  one-cycle completion pulse for requester N.
REQ-009 cN_mem_data  output  BLOCK_WORDS x DATA_BITS  filled block for requester N, word i at index i.
REQ-010 ram_address  output  RAM_ADDRESS_BITS  RAM word address.
REQ-011 ram_read_en / ram_write_en  output  1 each  RAM beat request, held until ram_ack.
REQ-012 ram_write_data  output  DATA_BITS  RAM write word.
REQ-013 ram_ack  input  1  RAM beat complete; read data valid in the same cycle.
REQ-014 ram_read_data  input  DATA_BITS  RAM read word.

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE, RESPOND; only IDLE samples requests.
REQ-016 IDLE: no request -> stay; else pick port (REQ-017), latch its address/write_data, owner, op; write pending on chosen port -> WRITE, otherwise -> READ.
REQ-017 Arbitration round-robin: only one port requesting -> that port; both requesting -> port != last_grant; last_grant updated on every grant.
REQ-018 Same port with read_en and write_en both high: write served first; read stays pending and is re-arbitrated from IDLE.
REQ-019 READ: ram_read_en=1, ram_address = {latched address upper bits, beat}, low BLOCK_BITS replaced by beat counter starting at 0; each ram_ack stores ram_read_data into buffer[beat], beat increments; ack on beat BLOCK_WORDS-1 -> RESPOND.
REQ-020 WRITE: ram_write_en=1, ram_address = latched address unmodified, ram_write_data = latched data; ram_ack -> RESPOND.
REQ-021 RESPOND: owner's cN_mem_valid=1 for exactly this cycle, cN_mem_data = buffer (don't-care after write); -> IDLE unconditionally.
REQ-022 ram_read_en and ram_write_en SHALL never be high together and SHALL be 0 outside READ/WRITE.
REQ-023 Non-owner port's mem_valid SHALL stay 0; cN_mem_data SHALL hold last value between responses.
REQ-024 Latency with ram_ack tied high: read = 1 + BLOCK_WORDS + 1 cycles from IDLE sample to mem_valid (6 at default); write = 3 cycles.
REQ-025 Request inputs changing after grant SHALL NOT affect the in-flight transaction.
REQ-026 ram_ack in IDLE/RESPOND SHALL be ignored.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, beat=0, last_grant=1 (port 0 wins first tie), all valids/ram enables 0, ram_address 0, buffer and cN_mem_data 0.
REQ-028 Reset mid-READ/WRITE SHALL abandon the transaction without any mem_valid pulse; after release both ports re-arbitrate from IDLE.

Verification
REQ-029 c0_read_en, address 'h10002, RAM returns 'hA0+beat, ack always high -> ram_address 'h10000..'h10003, c0_mem_valid 1 cycle 6 cycles later, c0_mem_data = {'hA0,'hA1,'hA2,'hA3}.
REQ-030 c1_write_en, address 'h20001, data 'haaaa, ack after 3-cycle delay -> ram_write_en held 3 cycles at 'h20001/'haaaa, c1_mem_valid pulse, c0_mem_valid stays 0.
REQ-031 Both ports read from reset, held -> grants alternate 0,1,0,1; no cycle with two valids; each valid matches owner's address block.
REQ-032 c0 read_en and write_en together, address 'h30000 -> WRITE to 'h30000 completes first, then 4-beat READ of 'h30000..'h30003.
REQ-033 reset_n low during beat 2 of a READ -> outputs zero asynchronously, no mem_valid; after release held request restarts at beat 0.
REQ-034 ram_ack pulsed while IDLE with no requests -> no state change, no outputs asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-beat RAM.
// Reads fetch a whole cache block one word per RAM beat. Writes push a
// single word. Each finished transaction is reported back to its
// requester with a one-cycle valid pulse.
module mem_arbiter #(
  parameter int RAM_ADDRESS_BITS = 32,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0]               c0_address,
  input  logic                                      c0_read_en,
  input  logic                                      c0_write_en,
  input  logic [DATA_BITS-1:0]                      c0_write_data,
  output logic                                      c0_mem_valid,
  output logic [(1<<BLOCK_BITS)-1:0][DATA_BITS-1:0] c0_mem_data,
  input  logic [RAM_ADDRESS_BITS-1:0]               c1_address,
  input  logic                                      c1_read_en,
  input  logic                                      c1_write_en,
  input  logic [DATA_BITS-1:0]                      c1_write_data,
  output logic                                      c1_mem_valid,
  output logic [(1<<BLOCK_BITS)-1:0][DATA_BITS-1:0] c1_mem_data,
  output logic [RAM_ADDRESS_BITS-1:0]               ram_address,
  output logic                                      ram_read_en,
  output logic                                      ram_write_en,
  output logic [DATA_BITS-1:0]                      ram_write_data,
  input  logic                                      ram_ack,
  input  logic [DATA_BITS-1:0]                      ram_read_data
);

  localparam int BLOCK_WORDS = 1 << BLOCK_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]                                state;
  logic [BLOCK_BITS-1:0]                     beat;
  logic                                      last_grant;
  logic                                      owner;
  logic [RAM_ADDRESS_BITS-1:0]               addr_q;
  logic [DATA_BITS-1:0]                      wdata_q;
  logic [BLOCK_WORDS-1:0][DATA_BITS-1:0]     buffer;
  logic [BLOCK_WORDS-1:0][DATA_BITS-1:0]     fill;

  logic                                      req0;
  logic                                      req1;
  logic                                      grant;
  logic                                      sel_write;
  logic [RAM_ADDRESS_BITS-1:0]               sel_addr;
  logic [DATA_BITS-1:0]                      sel_data;

  assign req0 = c0_read_en | c0_write_en;
  assign req1 = c1_read_en | c1_write_en;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  // A pending write on the chosen port goes first; its read waits for a later grant
  assign sel_write = grant ? c1_write_en   : c0_write_en;
  assign sel_addr  = grant ? c1_address    : c0_address;
  assign sel_data  = grant ? c1_write_data : c0_write_data;

  // Block buffer with the current beat's RAM word merged in, so the last beat lands in the response
  always_comb begin
    fill       = buffer;
    fill[beat] = ram_read_data;
  end

  // RAM-side outputs are driven only while a beat is outstanding, and are zero otherwise
  always_comb begin
    ram_read_en    = 1'b0;
    ram_write_en   = 1'b0;
    ram_address    = '0;
    ram_write_data = '0;
    case (state)
      READ: begin
        ram_read_en = 1'b1;
        ram_address = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], beat};
      end
      WRITE: begin
        ram_write_en   = 1'b1;
        ram_address    = addr_q;
        ram_write_data = wdata_q;
      end
      default: begin
        ram_read_en = 1'b0;
      end
    endcase
  end

  assign c0_mem_valid = (state == RESPOND) && !owner;
  assign c1_mem_valid = (state == RESPOND) && owner;

  // Transaction sequencer: grant in IDLE, walk the beats, pulse the owner, then return to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat        <= '0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buffer      <= '0;
      c0_mem_data <= '0;
      c1_mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= grant;
            last_grant <= grant;
            addr_q     <= sel_addr;
            wdata_q    <= sel_data;
            beat       <= '0;
            state      <= sel_write ? WRITE : READ;
          end
        end
        READ: begin
          if (ram_ack) begin
            buffer <= fill;
            beat   <= beat + BLOCK_BITS'(1);
            if (&beat) begin
              state <= RESPOND;
              if (owner) begin
                c1_mem_data <= fill;
              end else begin
                c0_mem_data <= fill;
              end
            end
          end
        end
        WRITE: begin
          if (ram_ack) begin
            state <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
